data_break_ctl: RTL and testbench

Single-channel data-break (DMA) controller between the RK8E disk controller and main memory. It accepts the RK8E's level-held `data_break` request with address, data and direction. It waits for the CPU to reach a major-cycle boundary, stalls the CPU, and runs one memory read or write. Read data is returned on `dmaDIN`.

---
 rtl/data_break_ctl_pkg.sv | 26 ++
 rtl/data_break_ctl_latency_ctr.sv | 28 ++
 rtl/data_break_ctl.sv | 97 +++++++++
 tb/tb_data_break_ctl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_break_ctl_pkg.sv
// Shared types for the RK8E data-break controller: FSM states, transfer direction, latched request.
// Combinational only (no latency); no backpressure.
package db_types;

  localparam int DB_LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SLOT,
    S_MEM,
    S_XFER,
    S_DONE
  } dbSTATE_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dbDIR_t;

  typedef struct packed {
    logic [0:14] addr;
    logic [0:11] data;
    dbDIR_t      dir;
  } db_req_t;

endpackage

// File: rtl/data_break_ctl_latency_ctr.sv
// Loadable down-counter; last=1 while the count is 1, i.e. the final cycle of the memory wait.
// Latency: load/dec take effect on the next edge; no backpressure, stops at zero.
module db_latency_ctr
  import db_types::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DB_LAT_W-1:0] load_val,
  input  logic                dec,
  output logic                last
);

  logic [DB_LAT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == DB_LAT_W'(1));

endmodule

// File: rtl/data_break_ctl.sv
// Single-channel data-break controller: waits for a CPU cycle boundary, stalls the CPU, runs one memory access.
// Latency: MEM_LAT+3 cycles from cycle_end to IDLE; requester holds data_break until break_in_prog.
module data_break_ctl
  import db_types::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        cycle_end,
  input  logic        data_break,
  input  logic        to_disk,
  input  logic [0:14] dmaAddr,
  input  logic [0:11] dmaDout,
  output logic        break_in_prog,
  output logic [0:11] dmaDIN,
  output logic        dma_rd_valid,
  output logic        cpu_hold,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [0:11] mem_rdata
);

  dbSTATE_t state, state_nxt;
  db_req_t  req;
  logic     ctr_last;

  db_latency_ctr u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == S_MEM),
    .load_val (DB_LAT_W'(MEM_LAT)),
    .dec      (state == S_XFER),
    .last     (ctr_last)
  );

  // clear only aborts before memory is touched; once in MEM the access runs to completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (data_break && !clear) state_nxt = S_WAIT_SLOT;
      S_WAIT_SLOT: begin
        if (clear)          state_nxt = S_IDLE;
        else if (cycle_end) state_nxt = S_MEM;
      end
      S_MEM:       state_nxt = S_XFER;
      S_XFER:      if (ctr_last) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      req           <= '0;
      break_in_prog <= 1'b0;
      dmaDIN        <= '0;
      dma_rd_valid  <= 1'b0;
      cpu_hold      <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_WAIT_SLOT) begin
        req <= '{addr: dmaAddr, data: dmaDout, dir: dbDIR_t'(to_disk)};
      end else if (state == S_WAIT_SLOT && clear) begin
        req <= '0;
      end
      break_in_prog <= (state == S_IDLE) && (state_nxt == S_WAIT_SLOT);
      cpu_hold      <= (state_nxt == S_MEM) || (state_nxt == S_XFER) || (state_nxt == S_DONE);
      mem_we        <= (state_nxt == S_MEM) && (req.dir == DIR_WR);
      mem_re        <= (state_nxt == S_MEM) && (req.dir == DIR_RD);
      dma_rd_valid  <= (state_nxt == S_DONE) && (req.dir == DIR_RD);
      if (state_nxt == S_MEM) begin
        mem_addr <= req.addr;
        if (req.dir == DIR_WR) mem_wdata <= req.data;
      end
      if (state == S_XFER && ctr_last && req.dir == DIR_RD) begin
        dmaDIN <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_break_ctl.sv
// Directed bench for data_break_ctl: two instances (MEM_LAT=1 and MEM_LAT=3) on shared stimulus.
module tb_data_break_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, clear = 1'b0, cycle_end = 1'b0, data_break = 1'b0, to_disk = 1'b0;
  logic [0:14] dmaAddr = '0;
  logic [0:11] dmaDout = '0;

  logic        bip1, vld1, hold1, we1, re1, bip3, vld3, hold3, we3, re3;
  logic [0:11] din1, wdata1, rdata1, din3, wdata3, rdata3;
  logic [0:14] addr1, addr3;

  // memory models: read data is valid only MEM_LAT cycles after mem_re, garbage otherwise
  logic       re1_d = 1'b0;
  logic [2:0] re3_d = 3'b000;
  always @(posedge clk) begin
    re1_d <= reset ? 1'b0 : re1;
    re3_d <= reset ? 3'b000 : {re3_d[1:0], re3};
  end
  assign rdata1 = re1_d    ? 12'o4321 : 12'o7777;
  assign rdata3 = re3_d[2] ? 12'o4321 : 12'o7777;

  data_break_ctl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .cycle_end(cycle_end), .data_break(data_break),
    .to_disk(to_disk), .dmaAddr(dmaAddr), .dmaDout(dmaDout), .break_in_prog(bip1),
    .dmaDIN(din1), .dma_rd_valid(vld1), .cpu_hold(hold1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_we(we1), .mem_re(re1), .mem_rdata(rdata1));

  data_break_ctl #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .cycle_end(cycle_end), .data_break(data_break),
    .to_disk(to_disk), .dmaAddr(dmaAddr), .dmaDout(dmaDout), .break_in_prog(bip3),
    .dmaDIN(din3), .dma_rd_valid(vld3), .cpu_hold(hold3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_we(we3), .mem_re(re3), .mem_rdata(rdata3));

  logic [43:0] o1, o3;
  assign o1 = {bip1, hold1, we1, re1, vld1, addr1, wdata1, din1};
  assign o3 = {bip3, hold3, we3, re3, vld3, addr3, wdata3, din3};

  typedef struct {
    logic        db, ce, dir;
    logic [0:14] addr;
    logic [0:11] dout;
    logic        bip, hold, we, re, vld;
    logic [0:14] maddr;
    logic [0:11] wdata, din;
  } vec_t;

  vec_t tbl[8];
  int   n_cmp = 0, n_bad = 0;
  int   c_bip1, c_we1, c_re1, c_hold1, c_vld1, c_bip3, c_we3, c_re3, c_hold3, c_vld3;

  function automatic vec_t mk(logic db, logic ce, logic dir, logic [0:14] addr, logic [0:11] dout,
                              logic bip, logic hold, logic we, logic re, logic vld,
                              logic [0:14] maddr, logic [0:11] wdata, logic [0:11] din);
    vec_t v;
    v.db = db; v.ce = ce; v.dir = dir; v.addr = addr; v.dout = dout;
    v.bip = bip; v.hold = hold; v.we = we; v.re = re; v.vld = vld;
    v.maddr = maddr; v.wdata = wdata; v.din = din;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic zero_counts();
    c_bip1 = 0; c_we1 = 0; c_re1 = 0; c_hold1 = 0; c_vld1 = 0;
    c_bip3 = 0; c_we3 = 0; c_re3 = 0; c_hold3 = 0; c_vld3 = 0;
  endtask

  // one clock; outputs sampled 1 time unit after the edge describe the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
    c_bip1 += int'(bip1); c_we1 += int'(we1); c_re1 += int'(re1);
    c_hold1 += int'(hold1); c_vld1 += int'(vld1);
    c_bip3 += int'(bip3); c_we3 += int'(we3); c_re3 += int'(re3);
    c_hold3 += int'(hold3); c_vld3 += int'(vld3);
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; cycle_end = 1'b0; data_break = 1'b0;
    tick(); tick();
    reset = 1'b0;
    zero_counts();
  endtask

  task automatic req(input logic dir, input logic [0:14] a, input logic [0:11] d);
    data_break = 1'b1; to_disk = dir; dmaAddr = a; dmaDout = d;
  endtask

  initial begin
    // write at MEM_LAT=1; request held two cycles past the acknowledge, inputs scrambled after capture
    tbl[0] = mk(1, 0, 0, 15'o12345, 12'o7070, 1, 0, 0, 0, 0, 15'o00000, 12'o0000, 12'o0000);
    tbl[1] = mk(1, 0, 1, 15'o77777, 12'o0000, 0, 0, 0, 0, 0, 15'o00000, 12'o0000, 12'o0000);
    tbl[2] = mk(1, 0, 1, 15'o77777, 12'o0000, 0, 0, 0, 0, 0, 15'o00000, 12'o0000, 12'o0000);
    tbl[3] = mk(0, 1, 1, 15'o77777, 12'o0000, 0, 1, 1, 0, 0, 15'o12345, 12'o7070, 12'o0000);
    tbl[4] = mk(0, 0, 1, 15'o77777, 12'o0000, 0, 1, 0, 0, 0, 15'o12345, 12'o7070, 12'o0000);
    tbl[5] = mk(0, 0, 1, 15'o77777, 12'o0000, 0, 1, 0, 0, 0, 15'o12345, 12'o7070, 12'o0000);
    tbl[6] = mk(0, 0, 1, 15'o77777, 12'o0000, 0, 0, 0, 0, 0, 15'o12345, 12'o7070, 12'o0000);
    tbl[7] = mk(0, 1, 1, 15'o77777, 12'o0000, 0, 0, 0, 0, 0, 15'o12345, 12'o7070, 12'o0000);

    do_reset();
    chk("reset_dut1", 64'(o1), 64'h0);
    chk("reset_dut3", 64'(o3), 64'h0);

    for (int i = 0; i < 8; i++) begin
      logic [43:0] e;
      data_break = tbl[i].db; cycle_end = tbl[i].ce; to_disk = tbl[i].dir;
      dmaAddr = tbl[i].addr; dmaDout = tbl[i].dout;
      tick();
      e = {tbl[i].bip, tbl[i].hold, tbl[i].we, tbl[i].re, tbl[i].vld,
           tbl[i].maddr, tbl[i].wdata, tbl[i].din};
      chk($sformatf("write_row%0d", i), 64'(o1), 64'(e));
    end
    chk("write_bip_count", 64'(c_bip1), 64'd1);
    chk("write_we_count", 64'(c_we1), 64'd1);
    chk("write_hold_cycles", 64'(c_hold1), 64'd3);

    // read at MEM_LAT=3, cycle_end already high in the acknowledge cycle
    do_reset();
    req(1'b1, 15'o00200, 12'o0000);
    tick();
    chk("read_bip", 64'(bip3), 64'd1);
    data_break = 1'b0; cycle_end = 1'b1;
    tick();
    chk("read_mem_cycle", 64'({re3, we3, hold3, addr3}), 64'({1'b1, 1'b0, 1'b1, 15'o00200}));
    cycle_end = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("read_xfer%0d", k), 64'({vld3, hold3}), 64'({1'b0, 1'b1}));
    end
    tick();
    chk("read_done", 64'({vld3, hold3, din3}), 64'({1'b1, 1'b1, 12'o4321}));
    tick();
    chk("read_idle", 64'({vld3, hold3, din3}), 64'({1'b0, 1'b0, 12'o4321}));
    chk("read_counts", 64'({8'(c_re3), 8'(c_we3), 8'(c_hold3), 8'(c_vld3)}), 64'({8'd1, 8'd0, 8'd5, 8'd1}));

    // reset while MEM_LAT=3 instance is in XFER with a previous read result held
    req(1'b1, 15'o00300, 12'o0000);
    tick();
    data_break = 1'b0; cycle_end = 1'b1;
    tick();
    cycle_end = 1'b0;
    tick(); tick();
    chk("midreset_hold_before", 64'(hold3), 64'd1);
    reset = 1'b1;
    tick();
    chk("midreset_dut3", 64'(o3), 64'h0);
    chk("midreset_dut1", 64'(o1), 64'h0);
    reset = 1'b0;
    req(1'b0, 15'o00400, 12'o0001);
    tick();
    chk("midreset_idle_capture", 64'(bip3), 64'd1);
    data_break = 1'b0;

    // clear while waiting for a slot
    do_reset();
    req(1'b0, 15'o01111, 12'o1111);
    tick();
    data_break = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; cycle_end = 1'b1;
    tick(); tick(); tick();
    chk("early_clear_no_mem", 64'({8'(c_we1), 8'(c_re1), 8'(c_hold1)}), 64'h0);
    cycle_end = 1'b0;
    req(1'b0, 15'o01111, 12'o1111);
    tick();
    chk("early_clear_back_idle", 64'(bip1), 64'd1);
    data_break = 1'b0;

    // clear during XFER of a write must not abort it
    do_reset();
    req(1'b0, 15'o02222, 12'o1234);
    tick();
    data_break = 1'b0; cycle_end = 1'b1;
    tick();
    chk("late_clear_we", 64'({we1, addr1, wdata1}), 64'({1'b1, 15'o02222, 12'o1234}));
    cycle_end = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    chk("late_clear_done", 64'(hold1), 64'd1);
    clear = 1'b0;
    tick();
    chk("late_clear_idle", 64'(hold1), 64'd0);
    tick(); tick(); tick();
    chk("late_clear_counts", 64'({8'(c_we1), 8'(c_hold1), 8'(c_we3), 8'(c_hold3)}),
        64'({8'd1, 8'd3, 8'd1, 8'd5}));

    // second request raised mid-transfer is taken only after an IDLE cycle
    do_reset();
    cycle_end = 1'b1;
    req(1'b0, 15'o03030, 12'o0101);
    tick();
    data_break = 1'b0;
    tick(); tick();
    req(1'b1, 15'o04040, 12'o0000);
    tick();
    chk("b2b_busy_ignored", 64'(bip1), 64'd0);
    tick();
    chk("b2b_idle_gap", 64'({bip1, hold1}), 64'd0);
    tick();
    chk("b2b_second_bip", 64'(bip1), 64'd1);
    data_break = 1'b0;
    tick();
    chk("b2b_second_read", 64'({re1, we1, addr1}), 64'({1'b1, 1'b0, 15'o04040}));
    tick(); tick();
    chk("b2b_read_data", 64'({vld1, din1}), 64'({1'b1, 12'o4321}));
    chk("b2b_counts", 64'({8'(c_bip1), 8'(c_we1), 8'(c_re1)}), 64'({8'd2, 8'd1, 8'd1}));
    cycle_end = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
